// File: rtl/hazard_ctrl.sv
// hazard_ctrl: register-hazard owner for decode -- EX/MEM shadow slots, in-flight scoreboard,
// forward selects and hazard stall. Optional macro HAZARD_MEM_FWD_EN enables forwarding from MEM.
`default_nettype none

module hazard_ctrl #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       de_valid,
  input  logic       de_issue,
  input  logic [4:0] de_rs1,
  input  logic [4:0] de_rs2,
  input  logic       de_use_rs1,
  input  logic       de_use_rs2,
  input  logic [4:0] de_rd,
  input  logic       de_is_load,
  input  logic       ex_stall,
  input  logic       wb_wen,
  input  logic [4:0] wb_wreg,
  output logic [1:0] forward_rs1,
  output logic [1:0] forward_rs2,
  output logic       hz_stall,
  output logic       hz_busy
);

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_EX   = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef HAZARD_MEM_FWD_EN
  localparam logic MEM_FWD = 1'b1;
`else
  localparam logic MEM_FWD = 1'b0;
`endif

  logic             ex_vld_q, ex_vld_d, ex_ld_q, ex_ld_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             mem_vld_q, mem_vld_d;
  logic [4:0]       mem_rd_q, mem_rd_d;
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];

  logic sb_inc, sb_dec, rd_full, blk1, blk2;

  always_comb begin
    ex_vld_d  = ex_vld_q;
    ex_rd_d   = ex_rd_q;
    ex_ld_d   = ex_ld_q;
    mem_vld_d = mem_vld_q;
    mem_rd_d  = mem_rd_q;
    if (!ex_stall) begin
      ex_vld_d  = de_issue;
      ex_rd_d   = de_issue ? de_rd : 5'd0;
      ex_ld_d   = de_issue & de_is_load;
      mem_vld_d = ex_vld_q;
      mem_rd_d  = ex_rd_q;
    end
  end

  assign sb_inc = de_issue && (de_rd != 5'd0);
  assign sb_dec = wb_wen && (wb_wreg != 5'd0);

  // A matched inc/dec pair cancels even when the counter sits at zero or saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (!(sb_inc && sb_dec && (de_rd == wb_wreg))) begin
      if (sb_inc && (cnt_q[de_rd] != CNT_MAX))
        cnt_d[de_rd] = cnt_q[de_rd] + 1'b1;
      if (sb_dec && (cnt_q[wb_wreg] != '0))
        cnt_d[wb_wreg] = cnt_q[wb_wreg] - 1'b1;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_vld_q  <= 1'b0;
      ex_rd_q   <= 5'd0;
      ex_ld_q   <= 1'b0;
      mem_vld_q <= 1'b0;
      mem_rd_q  <= 5'd0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      ex_vld_q  <= ex_vld_d;
      ex_rd_q   <= ex_rd_d;
      ex_ld_q   <= ex_ld_d;
      mem_vld_q <= mem_vld_d;
      mem_rd_q  <= mem_rd_d;
      cnt_q     <= cnt_d;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] s, input logic use_s);
    logic [1:0] sel;
    sel = SEL_NONE;
    if (use_s && (s != 5'd0)) begin
      if (ex_vld_q && (ex_rd_q == s) && !ex_ld_q)
        sel = SEL_EX;
      else if (MEM_FWD && mem_vld_q && (mem_rd_q == s))
        sel = SEL_MEM;
    end
    return sel;
  endfunction

  function automatic logic src_blocked(input logic [4:0] s, input logic use_s,
                                       input logic [1:0] sel);
    logic load_use, pending;
    load_use = ex_vld_q && (ex_rd_q == s) && ex_ld_q;
    // A same-cycle writeback is covered by register-file write-through.
    pending  = (sel == SEL_NONE) && (cnt_q[s] != '0) && !(wb_wen && (wb_wreg == s));
    return use_s && (s != 5'd0) && (load_use || pending);
  endfunction

  always_comb begin
    forward_rs1 = fwd_sel(de_rs1, de_use_rs1);
    forward_rs2 = fwd_sel(de_rs2, de_use_rs2);
    blk1        = src_blocked(de_rs1, de_use_rs1, forward_rs1);
    blk2        = src_blocked(de_rs2, de_use_rs2, forward_rs2);
    // A full rd counter holds decode whatever its sources, so the count can never overflow.
    rd_full     = (de_rd != 5'd0) && (cnt_q[de_rd] == CNT_MAX);
    hz_stall    = de_valid && (blk1 || blk2 || rd_full);
  end

  always_comb begin
    hz_busy = 1'b0;
    for (int i = 1; i < 32; i++) hz_busy = hz_busy | (cnt_q[i] != '0);
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with hand-computed expectations for hazard_ctrl.
`default_nettype none

module tb_hazard_ctrl;

`ifdef HAZARD_MEM_FWD_EN
  localparam logic MF = 1'b1;
`else
  localparam logic MF = 1'b0;
`endif
  localparam logic [1:0] MEM_SEL = MF ? 2'b10 : 2'b00;
  localparam logic [1:0] MEM_STL = MF ? 2'b00 : 2'b01;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       de_valid, de_issue, de_use_rs1, de_use_rs2, de_is_load;
  logic [4:0] de_rs1, de_rs2, de_rd, wb_wreg;
  logic       ex_stall, wb_wen;
  logic [1:0] forward_rs1, forward_rs2;
  logic       hz_stall, hz_busy;

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl #(.CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .de_valid(de_valid), .de_issue(de_issue),
    .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2),
    .de_rd(de_rd), .de_is_load(de_is_load),
    .ex_stall(ex_stall), .wb_wen(wb_wen), .wb_wreg(wb_wreg),
    .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
    .hz_stall(hz_stall), .hz_busy(hz_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    de_valid = 0; de_issue = 0; de_rs1 = 0; de_rs2 = 0; de_use_rs1 = 0; de_use_rs2 = 0;
    de_rd = 0; de_is_load = 0; ex_stall = 0; wb_wen = 0; wb_wreg = 0;
  endtask

  task automatic dec(input logic v, input logic iss, input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2, input logic [4:0] rd, input logic ld);
    de_valid = v; de_issue = iss; de_rs1 = r1; de_use_rs1 = u1; de_rs2 = r2; de_use_rs2 = u2;
    de_rd = rd; de_is_load = ld;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    step(); step();
    dec(1, 0, 5, 1, 0, 0, 0, 0); #1;
    chk("rst_fwd1", forward_rs1, 2'b00);
    chk("rst_fwd2", forward_rs2, 2'b00);
    chk("rst_stall", {1'b0, hz_stall}, 2'b00);
    chk("rst_busy", {1'b0, hz_busy}, 2'b00);
    step(); reset_n = 1'b1;
    dec(1, 0, 5, 1, 0, 0, 0, 0); #1;
    chk("nohist_fwd1", forward_rs1, 2'b00);
    chk("nohist_stall", {1'b0, hz_stall}, 2'b00);
    chk("nohist_busy", {1'b0, hz_busy}, 2'b00);

    // add x3, consumer next cycle, then a bubble and an rs2 consumer
    step(); dec(1, 1, 0, 0, 0, 0, 3, 0); #1;
    chk("add_issue_stall", {1'b0, hz_stall}, 2'b00);
    step(); dec(1, 0, 3, 1, 0, 0, 0, 0); #1;
    chk("ex_fwd1", forward_rs1, 2'b01);
    chk("ex_fwd_stall", {1'b0, hz_stall}, 2'b00);
    chk("ex_fwd_busy", {1'b0, hz_busy}, 2'b01);
    step(); dec(1, MF, 0, 0, 3, 1, 0, 0); #1;
    chk("mem_fwd2", forward_rs2, MEM_SEL);
    chk("mem_stall", {1'b0, hz_stall}, MEM_STL);
    step(); dec(1, 1, 0, 0, 3, 1, 0, 0); wb_wen = 1; wb_wreg = 3; #1;
    chk("wb_fwd2", forward_rs2, 2'b00);
    chk("wb_stall", {1'b0, hz_stall}, 2'b00);
    step(); #1;
    chk("wb_drained_busy", {1'b0, hz_busy}, 2'b00);

    // load-use
    step(); dec(1, 1, 0, 0, 0, 0, 7, 1); #1;
    chk("lw_issue_stall", {1'b0, hz_stall}, 2'b00);
    step(); dec(1, 0, 7, 1, 0, 0, 0, 0); #1;
    chk("lu_fwd1", forward_rs1, 2'b00);
    chk("lu_stall", {1'b0, hz_stall}, 2'b01);
    step(); dec(1, MF, 7, 1, 0, 0, 0, 0); #1;
    chk("lu_mem_fwd1", forward_rs1, MEM_SEL);
    chk("lu_mem_stall", {1'b0, hz_stall}, MEM_STL);
    step(); dec(1, 1, 7, 1, 0, 0, 0, 0); wb_wen = 1; wb_wreg = 7; #1;
    chk("lu_wb_fwd1", forward_rs1, 2'b00);
    chk("lu_wb_stall", {1'b0, hz_stall}, 2'b00);

    // x0 producer and consumer
    step(); dec(1, 1, 0, 1, 0, 0, 0, 0); #1;
    chk("x0_prod_stall", {1'b0, hz_stall}, 2'b00);
    step(); dec(1, 1, 0, 1, 0, 0, 0, 0); #1;
    chk("x0_fwd1", forward_rs1, 2'b00);
    chk("x0_stall", {1'b0, hz_stall}, 2'b00);
    chk("x0_busy", {1'b0, hz_busy}, 2'b00);

    // saturate cnt[9]
    step(); dec(1, 1, 0, 0, 0, 0, 9, 0); #1;
    chk("sat1_stall", {1'b0, hz_stall}, 2'b00);
    step(); dec(1, 1, 0, 0, 0, 0, 9, 0);
    step(); dec(1, 1, 0, 0, 0, 0, 9, 0); #1;
    chk("sat3_stall", {1'b0, hz_stall}, 2'b00);
    step(); dec(1, 0, 1, 1, 0, 0, 9, 0); #1;
    chk("sat_full_stall", {1'b0, hz_stall}, 2'b01);
    chk("sat_full_fwd1", forward_rs1, 2'b00);
    chk("sat_busy", {1'b0, hz_busy}, 2'b01);
    step(); dec(1, 1, 0, 0, 0, 0, 9, 0); wb_wen = 1; wb_wreg = 9;
    step(); dec(1, 0, 1, 1, 0, 0, 9, 0); #1;
    chk("sat_cancel_stall", {1'b0, hz_stall}, 2'b01);
    step(); wb_wen = 1; wb_wreg = 9;
    step(); dec(1, 0, 1, 1, 0, 0, 9, 0); #1;
    chk("sat_after_wb_stall", {1'b0, hz_stall}, 2'b00);
    step(); wb_wen = 1; wb_wreg = 9;
    step(); wb_wen = 1; wb_wreg = 9;
    step(); wb_wen = 1; wb_wreg = 9;
    step(); #1;
    chk("sat_drained_busy", {1'b0, hz_busy}, 2'b00);

    // producer held in EX by ex_stall, then async reset mid-stall
    step(); dec(1, 1, 0, 0, 0, 0, 4, 0);
    for (int i = 0; i < 3; i++) begin
      step(); dec(1, 0, 4, 1, 0, 0, 0, 0); ex_stall = 1; #1;
      chk("hold_fwd1", forward_rs1, 2'b01);
      chk("hold_stall", {1'b0, hz_stall}, 2'b00);
    end
    #1; reset_n = 1'b0; #1;
    chk("arst_fwd1", forward_rs1, 2'b00);
    chk("arst_stall", {1'b0, hz_stall}, 2'b00);
    chk("arst_busy", {1'b0, hz_busy}, 2'b00);
    step(); reset_n = 1'b1; dec(1, 0, 4, 1, 0, 0, 0, 0); #1;
    chk("post_rst_fwd1", forward_rs1, 2'b00);
    chk("post_rst_stall", {1'b0, hz_stall}, 2'b00);
    chk("post_rst_busy", {1'b0, hz_busy}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
